mcsr_row_scheduler: RTL and testbench

Run controller for the per-row MCSR sparse matrix-vector multiply (SMVM) MAC engines. Each engine is an HLS core using the ap_ctrl_hs handshake and has its own row-value and vector BRAMs. This block launches a selected set of row engines from one start pulse and follows each engine's start/ready/done handshake. It captures every row's y_o into a result register bank and reports completion, elapsed cycles and timeout. It sits between the top-level SMVM wrapper and the NUM_ROWS engines, replacing the tied-high ap_start.

---
 rtl/mcsr_row_scheduler_if.sv | 27 ++
 rtl/mcsr_row_scheduler.sv | 97 +++++++++
 tb/tb_mcsr_row_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcsr_row_scheduler_if.sv
// rtl/mcsr_row_scheduler_if.sv - ap_ctrl_hs handshake and result bus between scheduler and row engines
interface mcsr_row_scheduler_if #(
    parameter int NUM_ROWS = 5,
    parameter int DATA_W   = 32
);
    logic [NUM_ROWS-1:0]        eng_ap_start;
    logic [NUM_ROWS-1:0]        eng_ap_ready;
    logic [NUM_ROWS-1:0]        eng_ap_done;
    logic [NUM_ROWS*DATA_W-1:0] eng_y_o;
    logic [NUM_ROWS-1:0]        eng_y_o_ap_vld;

    modport master (
        output eng_ap_start,
        input  eng_ap_ready,
        input  eng_ap_done,
        input  eng_y_o,
        input  eng_y_o_ap_vld
    );

    modport slave (
        input  eng_ap_start,
        output eng_ap_ready,
        output eng_ap_done,
        output eng_y_o,
        output eng_y_o_ap_vld
    );
endinterface

// File: rtl/mcsr_row_scheduler.sv
// rtl/mcsr_row_scheduler.sv - launches masked MCSR row engines, captures y_o, reports done/timeout/cycles
module mcsr_row_scheduler #(
    parameter int NUM_ROWS = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       start,
    input  logic [NUM_ROWS-1:0]        row_mask,
    mcsr_row_scheduler_if.master       eng,
    output logic [NUM_ROWS*DATA_W-1:0] y_out,
    output logic [NUM_ROWS-1:0]        y_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [CNT_W-1:0]           cycles
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [NUM_ROWS-1:0] mask;
    logic [NUM_ROWS-1:0] pend;
    logic [NUM_ROWS-1:0] cmpl;
    logic [NUM_ROWS-1:0] cmpl_next;
    logic [NUM_ROWS-1:0] cap;

    // Unmasked rows start with cmpl=1, so only masked done pulses matter.
    always_comb begin
        cmpl_next = cmpl | (eng.eng_ap_done & mask);
        cap       = eng.eng_y_o_ap_vld & mask & ~y_valid;
    end

    assign eng.eng_ap_start = pend;
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state   <= S_IDLE;
            mask    <= '0;
            pend    <= '0;
            cmpl    <= '0;
            y_out   <= '0;
            y_valid <= '0;
            timeout <= 1'b0;
            cycles  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        mask    <= row_mask;
                        pend    <= row_mask;
                        cmpl    <= ~row_mask;
                        y_out   <= '0;
                        y_valid <= '0;
                        timeout <= 1'b0;
                        cycles  <= '0;
                    end
                end
                S_RUN: begin
                    pend    <= pend & ~eng.eng_ap_ready;
                    cmpl    <= cmpl_next;
                    y_valid <= y_valid | cap;
                    for (int i = 0; i < NUM_ROWS; i++) begin
                        if (cap[i]) begin
                            y_out[i*DATA_W +: DATA_W] <= eng.eng_y_o[i*DATA_W +: DATA_W];
                        end
                    end
                    if (!(&cycles)) begin
                        cycles <= cycles + 1'b1;
                    end
                    // A completion arriving on the timeout edge still counts as a clean finish.
                    if (&cmpl_next) begin
                        state <= S_DONE;
                        pend  <= '0;
                    end else if (cycles == TO_LAST) begin
                        state   <= S_DONE;
                        pend    <= '0;
                        timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mcsr_row_scheduler.sv
// tb/tb_mcsr_row_scheduler.sv - directed self-checking bench for mcsr_row_scheduler
module tb_mcsr_row_scheduler;
    localparam int NR = 5;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int TO = 32;

    logic                ap_clk = 1'b0;
    logic                ap_rst = 1'b1;
    logic                start = 1'b0;
    logic [NR-1:0]       row_mask = '0;
    logic [NR*DW-1:0]    y_out;
    logic [NR-1:0]       y_valid;
    logic                busy;
    logic                done;
    logic                timeout;
    logic [CW-1:0]       cycles;

    mcsr_row_scheduler_if #(.NUM_ROWS(NR), .DATA_W(DW)) eng_bus ();

    mcsr_row_scheduler #(
        .NUM_ROWS(NR), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .start    (start),
        .row_mask (row_mask),
        .eng      (eng_bus),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .cycles   (cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    // engine model schedule, in cycles after the start-accept edge
    int       rdy_k [NR];
    int       dn_k  [NR];
    logic [NR-1:0] vld_en;
    int       dup_k;
    int       xstart_k;
    int       rst_k;

    // per-run observations
    int            done_at;
    int            pulses;
    logic [NR-1:0] start_seen;
    logic [NR-1:0] start_k0;
    logic [NR-1:0] start_k2;
    logic [NR-1:0] start_k31;
    logic [NR-1:0] start_at_done;
    logic          busy_after;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] yrow(input int i);
        return y_out[i*DW +: DW];
    endfunction

    task automatic set_normal();
        for (int i = 0; i < NR; i++) begin
            rdy_k[i] = 1;
            dn_k[i]  = 4 + i;
        end
        vld_en   = '1;
        dup_k    = -1;
        xstart_k = -1;
        rst_k    = -1;
    endtask

    task automatic drive_idle();
        eng_bus.eng_ap_ready   = '0;
        eng_bus.eng_ap_done    = '0;
        eng_bus.eng_y_o_ap_vld = '0;
        eng_bus.eng_y_o        = '0;
    endtask

    task automatic drive(input int k);
        for (int i = 0; i < NR; i++) begin
            eng_bus.eng_ap_ready[i]   = (k == rdy_k[i]);
            eng_bus.eng_ap_done[i]    = (k == dn_k[i]);
            eng_bus.eng_y_o_ap_vld[i] = ((k == dn_k[i]) && vld_en[i]) || (i == 0 && k == dup_k);
            eng_bus.eng_y_o[i*DW +: DW] = (i == 0 && k == dup_k) ? 32'd999 : 32'(100 + i);
        end
    endtask

    task automatic run_job(input logic [NR-1:0] m);
        @(negedge ap_clk);
        start    = 1'b1;
        row_mask = m;
        done_at = -1; pulses = 0; start_seen = '0; start_k0 = '0;
        start_k2 = '0; start_k31 = '0; start_at_done = '1; busy_after = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge ap_clk);
            start = (k == xstart_k);
            if (k == xstart_k) row_mask = 5'b00001;
            if (rst_k >= 0 && k == rst_k + 1) begin
                ap_rst = 1'b0;
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_eng_start", eng_bus.eng_ap_start, '0);
                chk("rst_y_valid", y_valid, '0);
                chk("rst_y_out_any", |y_out, 1'b0);
                chk("rst_cycles", cycles, '0);
                chk("rst_timeout", timeout, 1'b0);
                break;
            end
            ap_rst = (k == rst_k);
            if (done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = k;
                    start_at_done = eng_bus.eng_ap_start;
                end
            end
            start_seen |= eng_bus.eng_ap_start;
            if (k == 0)  start_k0  = eng_bus.eng_ap_start;
            if (k == 2)  start_k2  = eng_bus.eng_ap_start;
            if (k == 31) start_k31 = eng_bus.eng_ap_start;
            if (done_at >= 0 && k == done_at + 1) begin
                busy_after = busy;
                break;
            end
            drive(k);
        end
        drive_idle();
        start = 1'b0;
    endtask

    initial begin
        drive_idle();
        set_normal();
        ap_rst = 1'b1;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_timeout", timeout, 1'b0);
        chk("reset_cycles", cycles, '0);
        chk("reset_y_valid", y_valid, '0);
        chk("reset_y_out_any", |y_out, 1'b0);
        chk("reset_eng_start", eng_bus.eng_ap_start, '0);

        // all five rows, ready at k=1, done+vld at k=4+i
        set_normal();
        run_job(5'b11111);
        chk("t1_start_k0", start_k0, 5'b11111);
        chk("t1_start_k2", start_k2, 5'b00000);
        chk("t1_done_at", done_at, 9);
        chk("t1_pulses", pulses, 1);
        chk("t1_busy_after", busy_after, 1'b0);
        chk("t1_cycles", cycles, 9);
        chk("t1_timeout", timeout, 1'b0);
        chk("t1_y_valid", y_valid, 5'b11111);
        for (int i = 0; i < NR; i++) chk($sformatf("t1_y_row%0d", i), yrow(i), 100 + i);

        // partial mask, unmasked rows still pulse ready/done/vld
        set_normal();
        run_job(5'b00101);
        chk("t2_start_seen", start_seen, 5'b00101);
        chk("t2_done_at", done_at, 7);
        chk("t2_cycles", cycles, 7);
        chk("t2_y_valid", y_valid, 5'b00101);
        chk("t2_y_row0", yrow(0), 100);
        chk("t2_y_row1", yrow(1), 0);
        chk("t2_y_row2", yrow(2), 102);
        chk("t2_y_row4", yrow(4), 0);

        // empty mask
        set_normal();
        run_job(5'b00000);
        chk("t3_done_at", done_at, 1);
        chk("t3_pulses", pulses, 1);
        chk("t3_cycles", cycles, 1);
        chk("t3_start_seen", start_seen, 5'b00000);
        chk("t3_y_valid", y_valid, 5'b00000);

        // row 3 never becomes ready nor done
        set_normal();
        rdy_k[3] = -1;
        dn_k[3]  = -1;
        run_job(5'b11111);
        chk("t4_done_at", done_at, 32);
        chk("t4_start_k31", start_k31, 5'b01000);
        chk("t4_start_at_done", start_at_done, 5'b00000);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_cycles", cycles, 32);
        chk("t4_y_valid", y_valid, 5'b10111);
        chk("t4_y_row3", yrow(3), 0);
        chk("t4_y_row4", yrow(4), 104);

        // start while busy, duplicate vld on row 0
        set_normal();
        xstart_k = 3;
        dup_k    = 6;
        run_job(5'b11111);
        chk("t5_done_at", done_at, 9);
        chk("t5_pulses", pulses, 1);
        chk("t5_busy_after", busy_after, 1'b0);
        chk("t5_y_row0", yrow(0), 100);
        chk("t5_y_valid", y_valid, 5'b11111);
        chk("t5_cycles", cycles, 9);

        // reset mid-run after rows 0 and 1 were captured
        set_normal();
        rst_k = 6;
        run_job(5'b11111);
        chk("t6_pulses", pulses, 0);
        set_normal();
        run_job(5'b11111);
        chk("t6_rerun_done_at", done_at, 9);
        chk("t6_rerun_cycles", cycles, 9);
        chk("t6_rerun_y_valid", y_valid, 5'b11111);
        chk("t6_rerun_y_row4", yrow(4), 104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
